// File: rtl/ksa_4bit_if.sv
// ksa_4bit operand/result bundle.
// master drives operands, slave returns results.
interface ksa_4bit_if;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       in_valid;
  logic [3:0] s;
  logic [3:0] c;
  logic       out_valid;

  modport master (
    output a, b, cin, in_valid,
    input  s, c, out_valid
  );

  modport slave (
    input  a, b, cin, in_valid,
    output s, c, out_valid
  );
endinterface

// File: rtl/ksa_4bit.sv
// Registered 4-bit Kogge-Stone adder, two-level prefix tree.
// KSA4BIT_IN_REG_EN adds an input register (latency 2).
module ksa_4bit (
  input  logic       clk,
  input  logic       rst_n,
  ksa_4bit_if.slave  bus
);

  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       op_cin;
  logic       op_vld;

`ifdef KSA4BIT_IN_REG_EN
  logic [3:0] a_d, a_q;
  logic [3:0] b_d, b_q;
  logic       cin_d, cin_q;
  logic       vin_d, vin_q;

  // Next values for the operand capture stage.
  always_comb begin
    a_d   = bus.a;
    b_d   = bus.b;
    cin_d = bus.cin;
    vin_d = bus.in_valid;
  end

  // Operand capture stage, cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      vin_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      cin_q <= cin_d;
      vin_q <= vin_d;
    end
  end

  assign op_a   = a_q;
  assign op_b   = b_q;
  assign op_cin = cin_q;
  assign op_vld = vin_q;
`else
  assign op_a   = bus.a;
  assign op_b   = bus.b;
  assign op_cin = bus.cin;
  assign op_vld = bus.in_valid;
`endif

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] g1;
  logic [3:1] p1;
  logic [3:0] gc;
  logic [3:0] s_d, s_q;
  logic [3:0] c_d, c_q;
  logic       vld_d, vld_q;

  // Prefix tree: bit g/p, span-1 level, span-2 level, sum.
  always_comb begin
    g = op_a & op_b;
    p = op_a ^ op_b;

    // Level 1: bit 0 absorbs cin (position -1, P=0).
    g1[0] = g[0] | (p[0] & op_cin);
    g1[1] = g[1] | (p[1] & g[0]);
    p1[1] = p[1] & p[0];
    g1[2] = g[2] | (p[2] & g[1]);
    p1[2] = p[2] & p[1];
    g1[3] = g[3] | (p[3] & g[2]);
    p1[3] = p[3] & p[2];

    // Level 2: span 2; bit 3 node also
    // takes cin so depth stays at two.
    gc[0] = g1[0];
    gc[1] = g1[1] | (p1[1] & op_cin);
    gc[2] = g1[2] | (p1[2] & g1[0]);
    gc[3] = g1[3]
          | (p1[3] & g1[1])
          | (p1[3] & p1[1] & op_cin);

    c_d   = gc;
    s_d   = p ^ {gc[2:0], op_cin};
    vld_d = op_vld;
  end

  // Result register, updates every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q   <= '0;
      c_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      c_q   <= c_d;
      vld_q <= vld_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.c         = c_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_ksa_4bit.sv
// Testbench for ksa_4bit: arithmetic reference model
// checked every cycle, plus literal directed vectors.
module tb_ksa_4bit;

`ifdef KSA4BIT_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   model_ok;

  ksa_4bit_if bus ();

  ksa_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {out_valid, c, s} from plain arithmetic.
  function automatic logic [8:0] ref_res(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       ci,
    input logic       v
  );
    int unsigned tot;
    int unsigned msk;
    logic [3:0]  cr;
    tot = int'(a) + int'(b) + int'(ci);
    for (int i = 0; i < 4; i++) begin
      msk = (32'd1 << (i + 1)) - 1;
      cr[i] = ((((int'(a) & msk) + (int'(b) & msk)
               + int'(ci)) >> (i + 1)) & 1) != 0;
    end
    ref_res = {v, cr, tot[3:0]};
  endfunction

  logic [8:0] pipe [LAT];

  // Model pipeline of depth LAT.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      model_ok <= 1'b1;
    end else begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= ref_res(bus.a, bus.b, bus.cin, bus.in_valid);
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      checks++;
      if ({bus.out_valid, bus.c, bus.s} !== pipe[LAT-1]) begin
        errors++;
        $display("FAIL model t=%0t got v=%b c=%b s=%b exp v=%b c=%b s=%b",
                 $time, bus.out_valid, bus.c, bus.s,
                 pipe[LAT-1][8], pipe[LAT-1][7:4], pipe[LAT-1][3:0]);
      end
    end
  end

  task automatic drive(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       ci,
    input logic       v
  );
    bus.a        = a;
    bus.b        = b;
    bus.cin      = ci;
    bus.in_valid = v;
  endtask

  task automatic lit(
    input string      nm,
    input logic [3:0] es,
    input logic [3:0] ec,
    input logic       ev
  );
    checks++;
    if (bus.s !== es || bus.c !== ec || bus.out_valid !== ev) begin
      errors++;
      $display("FAIL %s got s=%b c=%b v=%b exp s=%b c=%b v=%b",
               nm, bus.s, bus.c, bus.out_valid, es, ec, ev);
    end
  endtask

  // Apply one vector, wait the latency, check literal.
  task automatic vec(
    input string      nm,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       ci,
    input logic       v,
    input logic [3:0] es,
    input logic [3:0] ec
  );
    drive(a, b, ci, v);
    repeat (LAT) @(negedge clk);
    lit(nm, es, ec, v);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    model_ok = 1'b0;
    rst_n    = 1'b0;
    drive(4'b1111, 4'b1111, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    lit("reset", 4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;

    vec("t1",  4'b1001, 4'b1100, 1'b0, 1'b1, 4'b0101, 4'b1000);
    vec("t2",  4'b0001, 4'b1110, 1'b0, 1'b1, 4'b1111, 4'b0000);
    vec("t3",  4'b1111, 4'b1101, 1'b0, 1'b1, 4'b1100, 4'b1111);
    vec("t4a", 4'b1101, 4'b1000, 1'b0, 1'b1, 4'b0101, 4'b1000);
    vec("t4b", 4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b1111);
    vec("inv", 4'b0011, 4'b0001, 1'b1, 1'b0, 4'b0101, 4'b0011);
    vec("max", 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1111, 4'b1111);
    vec("zero", 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000);

    // Back-to-back stream, then reset mid-stream.
    for (int i = 0; i < 6; i++) begin
      drive(4'(i + 7), 4'(3 * i), 1'(i), 1'b1);
      @(negedge clk);
    end
    rst_n = 1'b0;
    drive(4'b1010, 4'b0110, 1'b1, 1'b1);
    @(negedge clk);
    lit("midrst", 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    lit("midrst2", 4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;
    vec("resume", 4'b1010, 4'b0110, 1'b1, 1'b1, 4'b0001, 4'b1110);

    // Exhaustive sweep, one operation per cycle.
    for (int k = 0; k < 512; k++) begin
      drive(4'(k >> 5), 4'(k >> 1), 1'(k), 1'b1);
      @(negedge clk);
    end
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    repeat (LAT + 2) @(negedge clk);
    lit("drain", 4'b0000, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
